// File: rtl/rf8_alu_seq_pkg.sv
// Shared definitions for the rf8 ALU sequencer and the 8x8 register file it drives.
package rf8_alu_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LDI = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MOV = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SHL = OP_W'(7);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD_A = 2'd1,
    S_RD_B = 2'd2,
    S_WB   = 2'd3
  } state_t;

  // Latched instruction; ra is not kept because rf_rsel itself captures it.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rb;
    logic [DATA_W-1:0] imm;
  } instr_t;

  // Ops that read only source A and skip the RD_B cycle.
  function automatic logic is_unary(input logic [OP_W-1:0] o);
    return (o == OP_MOV) || (o == OP_SHL);
  endfunction

endpackage

// File: rtl/rf8_alu_seq_alu8.sv
// Combinational 8-bit ALU: arithmetic, logic, immediate load, move and shift-left.
module alu8
  import rf8_alu_seq_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] res,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Bit DATA_W of the widened difference is the borrow (a < b).
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    res   = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        res   = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      OP_SUB: begin
        res   = diff[DATA_W-1:0];
        carry = diff[DATA_W];
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_LDI: res = imm;
      OP_MOV: res = a;
      OP_SHL: begin
        res   = {a[DATA_W-2:0], 1'b0};
        carry = a[DATA_W-1];
      end
      default: res = '0;
    endcase
    zero = (res == '0);
  end

endmodule

// File: rtl/rf8_alu_seq.sv
// Multi-cycle sequencer: accepts one three-address instruction, reads sources
// through the register file read port, and writes the ALU result back.
module rf8_alu_seq
  import rf8_alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] rf_q,
  output logic [ADDR_W-1:0] rf_rsel,
  output logic [ADDR_W-1:0] rf_wsel,
  output logic              rf_en,
  output logic [DATA_W-1:0] rf_d,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  state_t            state;
  state_t            state_next;
  instr_t            instr;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] res;
  logic              res_carry;
  logic              res_zero;
  logic              res_load;

  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_imm;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic              alu_zero;

  // State register.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, handshake, write strobe and result-load decode.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    rf_en      = 1'b0;
    done       = 1'b0;
    res_load   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = clr;
        if (in_valid) begin
          if (op == OP_LDI) begin
            state_next = S_WB;
            res_load   = 1'b1;
          end else begin
            state_next = S_RD_A;
          end
        end
      end
      S_RD_A: begin
        if (is_unary(instr.op)) begin
          state_next = S_WB;
          res_load   = 1'b1;
        end else begin
          state_next = S_RD_B;
        end
      end
      S_RD_B: begin
        state_next = S_WB;
        res_load   = 1'b1;
      end
      S_WB: begin
        rf_en      = clr;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operands come straight from the ports/read data before they are latched.
  always_comb begin
    alu_op  = instr.op;
    alu_imm = instr.imm;
    alu_a   = reg_a;
    if (state == S_IDLE) begin
      alu_op  = op;
      alu_imm = imm;
    end
    if (state == S_RD_A) begin
      alu_a = rf_q;
    end
  end

  alu8 u_alu (
    .op    (alu_op),
    .a     (alu_a),
    .b     (rf_q),
    .imm   (alu_imm),
    .res   (alu_res),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  // Instruction latch, read select and source A capture.
  always_ff @(posedge clk) begin
    if (!clr) begin
      instr   <= '0;
      rf_rsel <= '0;
      reg_a   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            instr.op  <= op;
            instr.rd  <= rd;
            instr.rb  <= rb;
            instr.imm <= imm;
            if (op != OP_LDI) begin
              rf_rsel <= ra;
            end
          end
        end
        S_RD_A: begin
          reg_a <= rf_q;
          if (!is_unary(instr.op)) begin
            rf_rsel <= instr.rb;
          end
        end
        default: ;
      endcase
    end
  end

  // Pending result and the architecturally visible result/flags.
  always_ff @(posedge clk) begin
    if (!clr) begin
      res       <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (res_load) begin
        res       <= alu_res;
        res_carry <= alu_carry;
        res_zero  <= alu_zero;
      end
      if (state == S_WB) begin
        result <= res;
        carry  <= res_carry;
        zero   <= res_zero;
      end
    end
  end

  assign rf_wsel = instr.rd;
  assign rf_d    = res;

endmodule

// File: tb/tb_rf8_alu_seq.sv
// Bench for rf8_alu_seq wired to an 8x8 register file; directed plan then random ops.
module tb_rf8_alu_seq;

  logic       clk = 1'b0;
  logic       clr;
  logic       rf_clr;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op, rd, ra, rb;
  logic [7:0] imm;
  logic [7:0] rf_q;
  logic [2:0] rf_rsel, rf_wsel;
  logic       rf_en;
  logic [7:0] rf_d;
  logic       done;
  logic [7:0] result;
  logic       carry, zero;

  always #5 clk = ~clk;

  rf8_alu_seq dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .rd       (rd),
    .ra       (ra),
    .rb       (rb),
    .imm      (imm),
    .rf_q     (rf_q),
    .rf_rsel  (rf_rsel),
    .rf_wsel  (rf_wsel),
    .rf_en    (rf_en),
    .rf_d     (rf_d),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .zero     (zero)
  );

  // Register file: combinational read, clocked write, own clear.
  logic [7:0] rf_mem [8];
  assign rf_q = rf_mem[rf_rsel];
  always @(posedge clk) begin
    if (!rf_clr) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= 8'h00;
    end else if (rf_en) begin
      rf_mem[rf_wsel] <= rf_d;
    end
  end

  int wr_count = 0;
  always @(posedge clk) if (rf_en) wr_count <= wr_count + 1;

  int n_checks = 0;
  int n_err    = 0;
  int ref_regs [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference semantics in plain integer arithmetic.
  function automatic void model(input int o, input int a, input int b, input int im,
                                output int r, output int c);
    r = 0;
    c = 0;
    case (o)
      0: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = im;
      6: r = a;
      7: begin r = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
      default: r = 0;
    endcase
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic run(input int o, input int d, input int a, input int b, input int im);
    int r, c, lat, cyc, w0;
    model(o, ref_regs[a], ref_regs[b], im, r, c);
    lat = (o == 5) ? 1 : ((o == 6 || o == 7) ? 2 : 3);
    chk("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op  = 3'(o);
    rd  = 3'(d);
    ra  = 3'(a);
    rb  = 3'(b);
    imm = 8'(im);
    w0  = wr_count;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!done) begin
        chk("busy_ready", 32'(in_ready), 32'd0);
        chk("busy_no_write", 32'(rf_en), 32'd0);
      end
    end while (!done && cyc < 8);
    chk("latency", 32'(cyc), 32'(lat));
    chk("wb_en", 32'(rf_en), 32'd1);
    chk("wb_sel", 32'(rf_wsel), 32'(d));
    chk("wb_data", 32'(rf_d), 32'(r));
    in_valid = 1'b0;
    @(negedge clk);
    ref_regs[d] = r;
    chk("rf_reg", 32'(rf_mem[d]), 32'(r));
    chk("result", 32'(result), 32'(r));
    chk("carry", 32'(carry), 32'(c));
    chk("zero", 32'(zero), (r == 0) ? 32'd1 : 32'd0);
    chk("one_write", 32'(wr_count - w0), 32'd1);
    chk("done_low", 32'(done), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int w0;
    clr = 1'b0; rf_clr = 1'b0; in_valid = 1'b0;
    op = '0; rd = '0; ra = '0; rb = '0; imm = '0;
    for (int i = 0; i < 8; i++) ref_regs[i] = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_en", 32'(rf_en), 32'd0);
    chk("rst_rsel", 32'(rf_rsel), 32'd0);
    chk("rst_wsel", 32'(rf_wsel), 32'd0);
    chk("rst_d", 32'(rf_d), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", {30'd0, carry, zero}, 32'd0);
    clr = 1'b1; rf_clr = 1'b1;
    @(negedge clk);

    // Directed plan, issued back-to-back.
    run(5, 1, 0, 0, 'h3C);
    run(5, 2, 0, 0, 'hC5);
    run(0, 3, 1, 2, 0);
    chk("plan_add", {24'd0, rf_mem[3]}, 32'h01);
    chk("plan_add_c", 32'(carry), 32'd1);
    run(4, 4, 1, 1, 0);
    chk("plan_xor_z", 32'(zero), 32'd1);
    run(1, 5, 1, 2, 0);
    chk("plan_sub1", {24'd0, rf_mem[5]}, 32'h77);
    chk("plan_sub1_c", 32'(carry), 32'd1);
    run(1, 5, 2, 1, 0);
    chk("plan_sub2", {24'd0, rf_mem[5]}, 32'h89);
    run(7, 6, 2, 0, 0);
    chk("plan_shl", {24'd0, rf_mem[6]}, 32'h8A);
    run(6, 7, 6, 0, 0);
    chk("plan_mov", {24'd0, rf_mem[7]}, 32'h8A);
    run(0, 1, 1, 1, 0);
    run(0, 2, 1, 1, 0);
    chk("plan_raw", {24'd0, rf_mem[2]}, 32'hF0);

    // Abort during RD_B with in_valid held throughout.
    w0 = wr_count;
    in_valid = 1'b1; op = 3'd0; rd = 3'd0; ra = 3'd1; rb = 3'd2; imm = 8'h00;
    @(negedge clk);
    chk("abort_busy", 32'(in_ready), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("abort_en", 32'(rf_en), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flags", {30'd0, carry, zero}, 32'd0);
    chk("abort_sels", {26'd0, rf_rsel, rf_wsel}, 32'd0);
    chk("abort_d", 32'(rf_d), 32'd0);
    chk("abort_r0", 32'(rf_mem[0]), 32'(ref_regs[0]));
    chk("abort_writes", 32'(wr_count - w0), 32'd0);
    in_valid = 1'b0; clr = 1'b1;
    @(negedge clk);
    chk("abort_idle", 32'(in_ready), 32'd1);

    // Clear landing in the WB cycle suppresses the write.
    w0 = wr_count;
    in_valid = 1'b1; op = 3'd5; rd = 3'd0; imm = 8'h55;
    @(negedge clk);
    chk("wbclr_done", 32'(done), 32'd1);
    clr = 1'b0;
    #1;
    chk("wbclr_en", 32'(rf_en), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("wbclr_r0", 32'(rf_mem[0]), 32'(ref_regs[0]));
    chk("wbclr_writes", 32'(wr_count - w0), 32'd0);
    clr = 1'b1;
    @(negedge clk);

    // Random instruction stream against the model.
    for (int k = 0; k < 60; k++) begin
      run(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
